scale_cache_ctrl: RTL and testbench

//  Fill/read sequencer for one scaleCache instance in the detector pyramid. Takes a raster source

---
 rtl/scale_cache_ctrl_pkg.sv | 25 ++
 rtl/scale_cache_ctrl_if.sv | 20 ++
 rtl/scale_cache_ctrl_rd_arb.sv | 24 ++
 rtl/scale_cache_ctrl.sv | 102 ++++++++++
 tb/tb_scale_cache_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/scale_cache_ctrl_pkg.sv
// scale_cache_ctrl_pkg: shared widths, cache geometry, FSM state and cache port structs
package scale_cache_ctrl_pkg;
    localparam int COORD_W = 10;
    localparam int STEP_W = 16;
    localparam int WORD_SIZE = 8;
    localparam int SCALE_ROW_SIZE = 320;
    localparam int WORDS = 320 * 240;
    localparam int MAX_ROWS = WORDS / SCALE_ROW_SIZE;
    localparam int STEP_FRAC = 8;
    localparam logic [STEP_W-1:0] STEP_ONE = 16'h0100;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, READY} state_t;
    typedef struct packed {
        logic [COORD_W-1:0] waddrY;
        logic [COORD_W-1:0] waddrX;
        logic [WORD_SIZE-1:0] wdata;
        logic we;
    } struct_scaleCache_Write;
    typedef struct packed {
        logic [COORD_W-1:0] raddrY;
        logic [COORD_W-1:0] raddrX;
    } struct_scaleCache_Read_In;
    typedef struct packed {
        logic [WORD_SIZE-1:0] q;
    } struct_scaleCache_Read_Out;
endpackage

// File: rtl/scale_cache_ctrl_if.sv
// scale_cache_ctrl_if: source stream, cache write/read ports and the two-requester read bus
interface scale_cache_ctrl_if;
    import scale_cache_ctrl_pkg::*;
    logic src_valid;
    logic src_ready;
    logic [WORD_SIZE-1:0] src_data;
    struct_scaleCache_Write scw;
    logic [1:0] rd_req;
    logic [1:0][COORD_W-1:0] rd_y;
    logic [1:0][COORD_W-1:0] rd_x;
    logic [1:0] rd_gnt;
    logic [1:0] rd_valid;
    logic [WORD_SIZE-1:0] rd_data;
    struct_scaleCache_Read_In scr_in;
    struct_scaleCache_Read_Out scr_out;
    modport slave(input src_valid, src_data, rd_req, rd_y, rd_x, scr_out,
                  output src_ready, scw, rd_gnt, rd_valid, rd_data, scr_in);
    modport master(output src_valid, src_data, rd_req, rd_y, rd_x, scr_out,
                   input src_ready, scw, rd_gnt, rd_valid, rd_data, scr_in);
endinterface

// File: rtl/scale_cache_ctrl_rd_arb.sv
// scale_cache_rd_arb: 2-way read arbiter plus rd_valid pipeline stage.
// SCALE_CACHE_CTRL_RR_ARB_EN selects round-robin; otherwise requester 0 has fixed priority.
module scale_cache_rd_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] valid
);
`ifdef SCALE_CACHE_CTRL_RR_ARB_EN
    logic prio;
    // prio=1 means requester 1 wins a tie
    assign gnt = en ? {req[1] & (prio | ~req[0]), req[0] & (~prio | ~req[1])} : 2'b00;
    always_ff @(posedge clk or posedge rst)
        if (rst) prio <= 1'b0;
        else if (|gnt) prio <= gnt[0];
`else
    assign gnt = en ? {req[1] & ~req[0], req[0]} : 2'b00;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) valid <= 2'b00;
        else valid <= gnt;
endmodule

// File: rtl/scale_cache_ctrl.sv
// scale_cache_ctrl: nearest-neighbour Q8.8 downsampling fill of a scale cache, then shared reads.
// SCALE_CACHE_CTRL_RR_ARB_EN selects round-robin read arbitration (default fixed priority).
module scale_cache_ctrl
    import scale_cache_ctrl_pkg::*;
#(
    parameter int SRC_W = 320,
    parameter int SRC_H = 240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STEP_W-1:0]  step,
    input  logic               frame_release,
    output logic               busy,
    output logic               frame_ready,
    output logic [COORD_W-1:0] dst_w,
    output logic [COORD_W-1:0] dst_h,
    scale_cache_ctrl_if.slave  bus
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SRC_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SRC_H - 1);
    localparam logic [COORD_W-1:0] ROW_LIM = COORD_W'(SCALE_ROW_SIZE);
    localparam logic [COORD_W-1:0] ROWS_LIM = COORD_W'(MAX_ROWS);
    state_t state;
    logic [STEP_W-1:0] step_r;
    logic [COORD_W-1:0] src_x, src_y, dst_x, dst_y;
    logic [COORD_W+7:0] nx, ny, step_ext;
    logic drain_cnt, accept, keep, line_end, row_hit;
    always_comb begin
        step_ext = (COORD_W+8)'(step_r);
        accept = bus.src_valid & bus.src_ready;
        row_hit = src_y == ny[COORD_W+7:STEP_FRAC];
        keep = accept && src_x == nx[COORD_W+7:STEP_FRAC] && row_hit && dst_x < ROW_LIM && dst_y < ROWS_LIM;
        line_end = accept && src_x == X_LAST;
        busy = state == FILL || state == DRAIN;
        frame_ready = state == READY;
        bus.src_ready = state == FILL;
        bus.scw = {dst_y, dst_x, bus.src_data, keep};
        bus.scr_in = bus.rd_gnt[1] ? {bus.rd_y[1], bus.rd_x[1]} : {bus.rd_y[0], bus.rd_x[0]};
        bus.rd_data = bus.scr_out.q;
        dst_h = dst_y;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step_r <= '0;
            src_x <= '0;
            src_y <= '0;
            dst_x <= '0;
            dst_y <= '0;
            dst_w <= '0;
            nx <= '0;
            ny <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= FILL;
                    step_r <= step < STEP_ONE ? STEP_ONE : step;
                    src_x <= '0;
                    src_y <= '0;
                    dst_x <= '0;
                    dst_y <= '0;
                    dst_w <= '0;
                    nx <= '0;
                    ny <= '0;
                end
                FILL: if (accept) begin
                    src_x <= line_end ? '0 : src_x + 1'b1;
                    nx <= line_end ? '0 : keep ? nx + step_ext : nx;
                    dst_x <= line_end ? '0 : dst_x + COORD_W'(keep);
                    if (line_end) begin
                        src_y <= src_y + 1'b1;
                        // a kept row closes: width is whatever this line produced
                        if (row_hit) begin
                            ny <= ny + step_ext;
                            dst_y <= dst_y + 1'b1;
                            dst_w <= dst_x + COORD_W'(keep);
                        end
                        if (src_y == Y_LAST) begin
                            state <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= READY;
                end
                READY: if (frame_release) state <= IDLE;
            endcase
        end
    end
    scale_cache_rd_arb u_arb (
        .clk(clk),
        .rst(rst),
        .en(state == READY),
        .req(bus.rd_req),
        .gnt(bus.rd_gnt),
        .valid(bus.rd_valid)
    );
endmodule

// File: tb/tb_scale_cache_ctrl.sv
// tb_scale_cache_ctrl: random-stimulus bench with a coordinate-map reference model and a cache RAM model.
module tb_scale_cache_ctrl;
    import scale_cache_ctrl_pkg::*;
    localparam int SW = 8;
    localparam int SH = 6;
`ifdef SCALE_CACHE_CTRL_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, frame_release = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic busy, frame_ready;
    logic [COORD_W-1:0] dst_w, dst_h;
    scale_cache_ctrl_if bus ();
    scale_cache_ctrl #(.SRC_W(SW), .SRC_H(SH)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .frame_release(frame_release),
        .busy(busy), .frame_ready(frame_ready), .dst_w(dst_w), .dst_h(dst_h), .bus(bus)
    );
    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cache model: write-through RAM with a registered read port
    logic [WORD_SIZE-1:0] mem [0:15][0:15];
    always @(posedge clk) begin
        if (bus.scw.we) mem[bus.scw.waddrY[3:0]][bus.scw.waddrX[3:0]] <= bus.scw.wdata;
        bus.scr_out.q <= mem[bus.scr_in.raddrY[3:0]][bus.scr_in.raddrX[3:0]];
    end

    // reference: destination index i samples source floor(i*step/256)
    int xmap [SW];
    int ymap [SH];
    int exp_w, exp_h, last_g = 1;
    logic [WORD_SIZE-1:0] img [0:15][0:15];
    function automatic void build(input logic [15:0] s_in);
        int s, i;
        s = s_in < 16'h0100 ? 256 : int'(s_in);
        foreach (xmap[k]) xmap[k] = -1;
        foreach (ymap[k]) ymap[k] = -1;
        i = 0;
        while (((i * s) >> 8) < SW) begin xmap[(i * s) >> 8] = i; i++; end
        exp_w = i;
        i = 0;
        while (((i * s) >> 8) < SH) begin ymap[(i * s) >> 8] = i; i++; end
        exp_h = i;
    endfunction

    task automatic run_frame(input logic [15:0] s, input bit ramp);
        int writes = 0;
        build(s);
        step = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        step = 16'($urandom);
        check("busy_start", busy, 1);
        bus.rd_req = 2'b11;
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) begin
                logic [WORD_SIZE-1:0] d;
                bit acc, kept;
                int tries;
                d = ramp ? WORD_SIZE'(y * SW + x) : WORD_SIZE'($urandom);
                bus.src_data = d;
                acc = 0;
                tries = 0;
                while (!acc) begin
                    bus.src_valid = $urandom_range(0, 3) != 0;
                    @(negedge clk);
                    acc = bus.src_valid && bus.src_ready;
                    kept = acc && xmap[x] >= 0 && ymap[y] >= 0;
                    check("src_ready_fill", bus.src_ready, 1);
                    check("gnt_fill", bus.rd_gnt, 0);
                    check("we", bus.scw.we, kept);
                    if (kept) begin
                        writes++;
                        check("waddr", {bus.scw.waddrY, bus.scw.waddrX}, {COORD_W'(ymap[y]), COORD_W'(xmap[x])});
                        check("wdata", bus.scw.wdata, d);
                        img[ymap[y]][xmap[x]] = d;
                    end
                    @(posedge clk); #1;
                    if (!acc && ++tries > 20) begin
                        check("src_timeout", 0, 1);
                        acc = 1;
                    end
                end
            end
        bus.src_valid = 1'b0;
        check("writes", writes, exp_w * exp_h);
        check("drain1_busy", busy, 1);
        check("drain1_ready", frame_ready, 0);
        check("drain1_gnt", bus.rd_gnt, 0);
        @(posedge clk); #1;
        check("drain2_ready", frame_ready, 0);
        check("drain2_gnt", bus.rd_gnt, 0);
        @(posedge clk); #1;
        bus.rd_req = 2'b00;
        check("ready", frame_ready, 1);
        check("ready_busy", busy, 0);
        check("dst_w", dst_w, exp_w);
        check("dst_h", dst_h, exp_h);
    endtask

    task automatic reads(input int n, input bit both, input bit rel_last);
        int pw = -1, py = 0, px = 0, w;
        for (int c = 0; c <= n; c++) begin
            bus.rd_req = c < n ? (both ? 2'b11 : 2'($urandom)) : 2'b00;
            for (int r = 0; r < 2; r++) begin
                bus.rd_y[r] = COORD_W'($urandom_range(0, exp_h - 1));
                bus.rd_x[r] = COORD_W'($urandom_range(0, exp_w - 1));
            end
            frame_release = rel_last && c == n - 1;
            @(negedge clk);
            w = bus.rd_req == 2'b00 ? -1 :
                (bus.rd_req == 2'b11 && RR && last_g == 0) ? 1 : bus.rd_req[0] ? 0 : 1;
            check("rd_gnt", bus.rd_gnt, w < 0 ? 64'd0 : 64'd1 << w);
            check("rd_valid", bus.rd_valid, pw < 0 ? 64'd0 : 64'd1 << pw);
            if (pw >= 0) check("rd_data", bus.rd_data, img[py][px]);
            pw = w;
            if (w >= 0) begin
                py = int'(bus.rd_y[w]);
                px = int'(bus.rd_x[w]);
                last_g = w;
            end
            @(posedge clk); #1;
        end
        frame_release = 1'b0;
    endtask

    task automatic release_frame();
        reads(3, 0, 1);
        check("rel_ready", frame_ready, 0);
        check("rel_busy", busy, 0);
        check("rel_src_ready", bus.src_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.rd_req = 2'b00;
        bus.rd_y = '0;
        bus.rd_x = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_dst", {dst_w, dst_h}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_src_ready", bus.src_ready, 0);
        run_frame(16'h0100, 1);
        reads(4, 1, 0);
        reads(20, 0, 0);
        step = 16'h0200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_ready", frame_ready, 1);
        check("start_in_ready_busy", busy, 0);
        check("start_in_ready_w", dst_w, exp_w);
        release_frame();
        run_frame(16'h0200, 0);
        reads(12, 1, 0);
        release_frame();
        run_frame(16'h0180, 0);
        reads(12, 0, 0);
        release_frame();
        run_frame(16'h0080, 0);
        reads(8, 0, 0);
        release_frame();
        for (int k = 0; k < 3; k++) begin
            run_frame(16'($urandom_range(16'h0100, 16'h0300)), 0);
            reads(10, k == 0, 0);
            release_frame();
        end
        step = 16'h0100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.src_valid = 1'b1;
        bus.rd_req = 2'b11;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_src_ready", bus.src_ready, 0);
        check("mid_rst_we", bus.scw.we, 0);
        check("mid_rst_rd", {bus.rd_gnt, bus.rd_valid}, 0);
        check("mid_rst_dst", {dst_w, dst_h}, 0);
        last_g = 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_src_ready", bus.src_ready, 0);
            check("post_rst_we", bus.scw.we, 0);
        end
        bus.src_valid = 1'b0;
        bus.rd_req = 2'b00;
        @(posedge clk); #1;
        run_frame(16'h0100, 0);
        reads(4, 1, 0);
        release_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
